// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one synchronous single-port RAM between a video reader and a CPU.
// Video reads have absolute priority and are serviced the same cycle as vid_rd; the CPU
// is stalled through cpu_wait until its access completes.
// Ports: clk_pixel/nreset (clock, async active-low reset); vid_addr/vid_rd/vid_dout (video
// read port); cpu_addr/cpu_rd/cpu_wr/cpu_din/cpu_dout/cpu_wait (CPU port);
// ram_addr/ram_we/ram_wdata/ram_dout (RAM port, 1-cycle read latency).
module vram_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_pixel,
    input  logic                  nreset,
    input  logic [ADDR_WIDTH-1:0] vid_addr,
    input  logic                  vid_rd,
    output logic [DATA_WIDTH-1:0] vid_dout,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic                  cpu_rd,
    input  logic                  cpu_wr,
    input  logic [DATA_WIDTH-1:0] cpu_din,
    output logic [DATA_WIDTH-1:0] cpu_dout,
    output logic                  cpu_wait,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_dout
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CPU_RD = 2'd1;
    localparam logic [1:0] S_ACK    = 2'd2;
    logic [1:0]            r_state;
    logic                  r_vid_pend;
    logic [DATA_WIDTH-1:0] r_vid_hold;
    logic [DATA_WIDTH-1:0] r_cpu_dout;
    logic                  w_cpu_slot;
    logic                  w_issue_wr;
    logic                  w_issue_rd;
    // The CPU may only start an access from IDLE in a cycle the video port leaves free.
    assign w_cpu_slot = (r_state == S_IDLE) & ~vid_rd;
    assign w_issue_wr = w_cpu_slot & cpu_wr;
    assign w_issue_rd = w_cpu_slot & cpu_rd & ~cpu_wr;
    assign ram_addr   = vid_rd ? vid_addr : cpu_addr;
    // Gating with nreset keeps a write issued in the reset cycle from reaching the RAM.
    assign ram_we     = w_issue_wr & nreset;
    assign ram_wdata  = cpu_din;
    assign vid_dout   = r_vid_pend ? ram_dout : r_vid_hold;
    assign cpu_dout   = r_cpu_dout;
    assign cpu_wait   = (cpu_rd | cpu_wr) & (r_state != S_ACK);
    always_ff @(posedge clk_pixel or negedge nreset) begin
        if (!nreset) begin
            r_state    <= S_IDLE;
            r_vid_pend <= 1'b0;
            r_vid_hold <= '0;
            r_cpu_dout <= '0;
        end else begin
            r_vid_pend <= vid_rd;
            if (r_vid_pend) r_vid_hold <= ram_dout;
            if (r_state == S_CPU_RD) r_cpu_dout <= ram_dout;
            r_state <= w_issue_wr ? S_ACK :
                       w_issue_rd ? S_CPU_RD :
                       (r_state == S_CPU_RD) ? S_ACK : S_IDLE;
        end
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed self-checking bench for vram_arbiter with a behavioural sync RAM.
module tb_vram_arbiter;
    logic        clk_pixel = 1'b0;
    logic        nreset;
    logic [15:0] vid_addr;
    logic        vid_rd;
    logic [7:0]  vid_dout;
    logic [15:0] cpu_addr;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;
    logic        cpu_wait;
    logic [15:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_dout;
    logic [7:0]  mem [0:65535];
    int          n_total = 0;
    int          n_bad   = 0;

    vram_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) dut (
        .clk_pixel(clk_pixel), .nreset(nreset),
        .vid_addr(vid_addr), .vid_rd(vid_rd), .vid_dout(vid_dout),
        .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .cpu_wait(cpu_wait),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_dout(ram_dout)
    );

    always #5 clk_pixel = ~clk_pixel;

    always @(posedge clk_pixel) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_dout <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_pixel);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'hF600] = 8'h41;
        mem[16'hFFFF] = 8'hC3;
        mem[16'h2000] = 8'h99;
        mem[16'h3000] = 8'hAB;
        mem[16'h4000] = 8'hCD;
        ram_dout = 8'h00;
        nreset = 1'b0;
        vid_addr = '0; vid_rd = 1'b0;
        cpu_addr = '0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_din = '0;
        #2;
        chk("rst_cpu_dout", cpu_dout, 0);
        chk("rst_vid_dout", vid_dout, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_cpu_wait", cpu_wait, 0);
        @(posedge clk_pixel);
        @(posedge clk_pixel);
        #3 nreset = 1'b1;

        // CPU write with idle video
        step();
        cpu_wr = 1'b1; cpu_addr = 16'h1234; cpu_din = 8'h5A;
        #1;
        chk("wr_we", ram_we, 1);
        chk("wr_addr", ram_addr, 16'h1234);
        chk("wr_wdata", ram_wdata, 8'h5A);
        chk("wr_wait1", cpu_wait, 1);
        step();
        chk("wr_ack_we", ram_we, 0);
        chk("wr_wait2", cpu_wait, 0);
        cpu_wr = 1'b0;
        step();
        chk("wr_mem", mem[16'h1234], 8'h5A);

        // CPU read with idle video
        cpu_rd = 1'b1; cpu_addr = 16'hF600;
        #1;
        chk("rd_addr", ram_addr, 16'hF600);
        chk("rd_we", ram_we, 0);
        chk("rd_wait1", cpu_wait, 1);
        step();
        chk("rd_wait2", cpu_wait, 1);
        chk("rd_dout_hold", cpu_dout, 0);
        step();
        chk("rd_wait3", cpu_wait, 0);
        chk("rd_dout", cpu_dout, 8'h41);
        cpu_rd = 1'b0;
        step();

        // Contention: video and CPU read in the same cycle
        cpu_rd = 1'b1; cpu_addr = 16'h2000; vid_rd = 1'b1; vid_addr = 16'hFFFF;
        #1;
        chk("ct_addr_vid", ram_addr, 16'hFFFF);
        chk("ct_we", ram_we, 0);
        chk("ct_wait1", cpu_wait, 1);
        step();
        vid_rd = 1'b0;
        #1;
        chk("ct_vid_dout", vid_dout, 8'hC3);
        chk("ct_addr_cpu", ram_addr, 16'h2000);
        chk("ct_wait2", cpu_wait, 1);
        step();
        chk("ct_wait3", cpu_wait, 1);
        chk("ct_vid_hold", vid_dout, 8'hC3);
        step();
        chk("ct_wait4", cpu_wait, 0);
        chk("ct_cpu_dout", cpu_dout, 8'h99);
        cpu_rd = 1'b0;
        step();

        // Interleave: video read during CPU_RD
        cpu_rd = 1'b1; cpu_addr = 16'h3000;
        #1;
        chk("il_addr_cpu", ram_addr, 16'h3000);
        step();
        vid_rd = 1'b1; vid_addr = 16'h4000;
        #1;
        chk("il_addr_vid", ram_addr, 16'h4000);
        chk("il_wait", cpu_wait, 1);
        step();
        vid_rd = 1'b0; cpu_rd = 1'b0;
        #1;
        chk("il_cpu_dout", cpu_dout, 8'hAB);
        chk("il_vid_dout", vid_dout, 8'hCD);
        for (int i = 0; i < 7; i++) begin
            step();
            chk($sformatf("il_hold%0d", i), vid_dout, 8'hCD);
        end

        // Simultaneous read and write is a write
        cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_addr = 16'h0010; cpu_din = 8'h77;
        #1;
        chk("rw_we", ram_we, 1);
        chk("rw_addr", ram_addr, 16'h0010);
        step();
        chk("rw_wait", cpu_wait, 0);
        chk("rw_cpu_dout", cpu_dout, 8'hAB);
        cpu_rd = 1'b0; cpu_wr = 1'b0;
        step();
        chk("rw_mem", mem[16'h0010], 8'h77);
        chk("rw_cpu_dout2", cpu_dout, 8'hAB);

        // Reset during CPU_RD aborts the access
        cpu_rd = 1'b1; cpu_addr = 16'hF600;
        step();
        #2 nreset = 1'b0;
        #1;
        chk("mr_cpu_dout", cpu_dout, 0);
        chk("mr_vid_dout", vid_dout, 0);
        cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_addr = 16'h5000; cpu_din = 8'h11;
        #1;
        chk("mr_we_forced", ram_we, 0);
        step();
        chk("mr_no_ack", cpu_wait, 1);
        chk("mr_we_forced2", ram_we, 0);
        chk("mr_mem_untouched", mem[16'h5000], 8'h00);
        #2 nreset = 1'b1;
        #1;
        chk("mr_we_after", ram_we, 1);
        step();
        chk("mr_ack", cpu_wait, 0);
        cpu_wr = 1'b0;
        step();
        chk("mr_mem", mem[16'h5000], 8'h11);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
